// File: rtl/axis_line_packer.sv
`default_nettype none
// ============================================================================
// Module   : axis_line_packer
// Brief    : Packs AXI-Stream byte elements into LANES-wide lines (runtime
//            length, early close on TLAST) and queues them in a FWFT FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module axis_line_packer #(
    parameter int C_S_AXIS_TDATA_WIDTH = 32,
    parameter int ELEM_WIDTH           = 5,
    parameter int LANES                = 256,
    parameter int DEPTH                = 4,
    parameter int LEN_WIDTH            = 12,
    parameter int CNT_WIDTH            = $clog2(DEPTH)
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [C_S_AXIS_TDATA_WIDTH-1:0]   S_AXIS_TDATA,
    input  logic [C_S_AXIS_TDATA_WIDTH/8-1:0] S_AXIS_TSTRB,
    input  logic                              S_AXIS_TLAST,
    input  logic                              S_AXIS_TVALID,
    output logic                              S_AXIS_TREADY,
    input  logic [LEN_WIDTH-1:0]              line_len,
    input  logic                              soft_clear,
    output logic [ELEM_WIDTH*LANES-1:0]       line_out,
    output logic                              line_valid,
    input  logic                              line_ready,
    output logic                              line_last,
    output logic [CNT_WIDTH:0]                fifo_cnt,
    output logic                              fifo_full,
    output logic                              len_err
);

    localparam int c_EPB    = C_S_AXIS_TDATA_WIDTH / 8;
    localparam int c_LINE_W = ELEM_WIDTH * LANES;
    localparam int c_LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int c_PTR_W  = LEN_WIDTH + 1;

    localparam logic [0:0] c_ST_FILL   = 1'b0;
    localparam logic [0:0] c_ST_COMMIT = 1'b1;

    // ------------------------------------------------------------------
    // Accumulator / FSM state
    // ------------------------------------------------------------------
    logic [0:0]            r_state;
    logic [0:0]            w_state_nxt;
    logic                  r_tready;
    logic [c_PTR_W-1:0]    r_elem_ptr;
    logic [LEN_WIDTH-1:0]  r_len_lat;
    logic                  r_last_lat;
    logic                  r_len_err;
    logic [ELEM_WIDTH-1:0] r_acc [LANES];
    logic [c_LINE_W-1:0]   w_line;

    logic                  w_accept;
    logic                  w_first;
    logic                  w_len_bad;
    logic [LEN_WIDTH-1:0]  w_len_samp;
    logic [LEN_WIDTH-1:0]  w_len_cur;
    logic [c_PTR_W-1:0]    w_len_ext;
    logic [c_PTR_W-1:0]    w_ptr_next;
    logic                  w_close;

    logic [c_LANE_W-1:0]   w_idx  [c_EPB];
    logic [ELEM_WIDTH-1:0] w_lane [c_EPB];

    // ------------------------------------------------------------------
    // Line FIFO state
    // ------------------------------------------------------------------
    logic [c_LINE_W-1:0]   r_mem      [DEPTH];
    logic                  r_last_mem [DEPTH];
    logic [CNT_WIDTH-1:0]  r_wr_ptr;
    logic [CNT_WIDTH-1:0]  r_rd_ptr;
    logic [CNT_WIDTH:0]    r_cnt;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_pop;

    // Only the low ELEM_WIDTH bits of each byte carry element data.
    logic w_unused_ok;
    assign w_unused_ok = &{1'b0, S_AXIS_TDATA};

    assign w_accept   = S_AXIS_TVALID && r_tready && !soft_clear;
    assign w_first    = (r_elem_ptr == '0);
    assign w_len_bad  = (line_len == '0) || (line_len > LEN_WIDTH'(LANES));
    assign w_len_samp = w_len_bad ? LEN_WIDTH'(LANES) : line_len;
    assign w_len_cur  = w_first ? w_len_samp : r_len_lat;
    assign w_len_ext  = {1'b0, w_len_cur};
    assign w_ptr_next = r_elem_ptr + c_PTR_W'(c_EPB);
    assign w_close    = w_accept && ((w_ptr_next >= w_len_ext) || S_AXIS_TLAST);

    assign w_full  = (r_cnt == (CNT_WIDTH+1)'(DEPTH));
    assign w_empty = (r_cnt == '0);
    assign w_pop   = !w_empty && line_ready && !soft_clear;
    assign w_push  = (r_state == c_ST_COMMIT) && (!w_full || w_pop) && !soft_clear;

    // Lanes beyond the latched length are zeroed so a partial beat truncates.
    always_comb begin
        for (int k = 0; k < c_EPB; k++) begin
            w_idx[k]  = c_LANE_W'(r_elem_ptr + c_PTR_W'(k));
            w_lane[k] = '0;
            if (S_AXIS_TSTRB[k] && ((r_elem_ptr + c_PTR_W'(k)) < w_len_ext)) begin
                w_lane[k] = S_AXIS_TDATA[8*k +: ELEM_WIDTH];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (soft_clear) begin
            w_state_nxt = c_ST_FILL;
        end else begin
            case (r_state)
                c_ST_FILL:   if (w_close) w_state_nxt = c_ST_COMMIT;
                c_ST_COMMIT: if (w_push)  w_state_nxt = c_ST_FILL;
                default:     w_state_nxt = c_ST_FILL;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_ST_FILL;
            r_tready   <= 1'b0;
            r_elem_ptr <= '0;
            r_len_lat  <= '0;
            r_last_lat <= 1'b0;
            r_len_err  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_tready <= (w_state_nxt == c_ST_FILL);
            if (soft_clear) begin
                r_elem_ptr <= '0;
                r_len_lat  <= '0;
                r_last_lat <= 1'b0;
                r_len_err  <= 1'b0;
            end else if (w_push) begin
                r_elem_ptr <= '0;
                r_last_lat <= 1'b0;
            end else if (w_accept) begin
                r_elem_ptr <= w_ptr_next;
                if (S_AXIS_TLAST) r_last_lat <= 1'b1;
                if (w_first) begin
                    r_len_lat <= w_len_samp;
                    if (w_len_bad) r_len_err <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LANES; i++) r_acc[i] <= '0;
        end else if (soft_clear || w_push) begin
            for (int i = 0; i < LANES; i++) r_acc[i] <= '0;
        end else if (w_accept) begin
            for (int k = 0; k < c_EPB; k++) r_acc[w_idx[k]] <= w_lane[k];
        end
    end

    generate
        for (genvar i = 0; i < LANES; i++) begin : g_pack
            assign w_line[i*ELEM_WIDTH +: ELEM_WIDTH] = r_acc[i];
        end
    endgenerate

    // ------------------------------------------------------------------
    // FWFT line FIFO
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr]      <= w_line;
            r_last_mem[r_wr_ptr] <= r_last_lat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else if (soft_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + CNT_WIDTH'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + CNT_WIDTH'(1);
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + (CNT_WIDTH+1)'(1);
                2'b01:   r_cnt <= r_cnt - (CNT_WIDTH+1)'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    assign S_AXIS_TREADY = r_tready;
    assign line_valid    = !w_empty;
    assign line_out      = w_empty ? '0   : r_mem[r_rd_ptr];
    assign line_last     = w_empty ? 1'b0 : r_last_mem[r_rd_ptr];
    assign fifo_cnt      = r_cnt;
    assign fifo_full     = w_full;
    assign len_err       = r_len_err;

endmodule
`default_nettype wire
